mem_ctrl: RTL and testbench

Memory controller directly downstream of the multicycle CPU's memory bus.
- Services one word transaction at a time (instruction fetch, load or store) from a unified synchronous-read RAM, or from a small memory-mapped I/O block.
- Uses a req/ready handshake with configurable RAM wait states, so the CPU controller stalls until ready.
- Flags misaligned and unmapped accesses with err.

---
 rtl/mem_ctrl.sv | 123 ++++++++++++
 tb/tb_mem_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Word-wide memory controller between the CPU bus and a synchronous-read RAM,
// with a two-register I/O block (switches/LEDs and a free-running cycle counter).
module mem_ctrl #(
    parameter int          MEM_WORDS   = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req,
    input  logic                         we,
    input  logic [31:0]                  addr,
    input  logic [31:0]                  wdata,
    output logic [31:0]                  rdata,
    output logic                         ready,
    output logic                         err,
    output logic                         ram_en,
    output logic                         ram_we,
    output logic [$clog2(MEM_WORDS)-1:0] ram_addr,
    output logic [31:0]                  ram_wdata,
    input  logic [31:0]                  ram_rdata,
    input  logic [7:0]                   sw_in,
    output logic [7:0]                   led_out
);
    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) * 33'd4;
    localparam logic [31:0] MMIO_IO   = MMIO_BASE;
    localparam logic [31:0] MMIO_CNT  = MMIO_BASE + 32'd4;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] waddr;
        logic [31:0]   wdata;
    } txn_t;

    state_t      state;
    txn_t        cur;
    logic [3:0]  wait_cnt;
    logic [31:0] cycle_cnt;
    logic        in_ram;

    assign in_ram = ({1'b0, addr} < RAM_BYTES);

    // RAM strobes are decoded from state so an async reset kills them at once.
    assign ram_en    = (state == ACCESS);
    assign ram_we    = ram_en & cur.we;
    assign ram_addr  = ram_en ? cur.waddr : '0;
    assign ram_wdata = ram_en ? cur.wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cycle_cnt <= '0;
        else        cycle_cnt <= cycle_cnt + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur      <= '0;
            wait_cnt <= '0;
            ready    <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            led_out  <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    cur <= '{we: we, waddr: addr[2 +: AW], wdata: wdata};
                    if (addr[1:0] != 2'b00) begin
                        state <= RESP;
                        ready <= 1'b1;
                        err   <= 1'b1;
                        rdata <= '0;
                    end else if (in_ram) begin
                        state <= ACCESS;
                    end else if (addr == MMIO_IO) begin
                        state <= RESP;
                        ready <= 1'b1;
                        err   <= 1'b0;
                        if (we) begin
                            led_out <= wdata[7:0];
                            rdata   <= '0;
                        end else begin
                            rdata   <= {24'b0, sw_in};
                        end
                    end else if (addr == MMIO_CNT) begin
                        // counter register is read-only; writes complete silently
                        state <= RESP;
                        ready <= 1'b1;
                        err   <= 1'b0;
                        rdata <= we ? 32'd0 : cycle_cnt;
                    end else begin
                        state <= RESP;
                        ready <= 1'b1;
                        err   <= 1'b1;
                        rdata <= '0;
                    end
                end
                ACCESS: begin
                    state    <= WAIT;
                    wait_cnt <= 4'(WAIT_CYCLES);
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= RESP;
                        ready <= 1'b1;
                        err   <= 1'b0;
                        rdata <= cur.we ? 32'd0 : ram_rdata;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    ready <= 1'b0;
                    err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed vector table, multi-cycle corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_mem_ctrl;
    localparam int          MEM_WORDS = 256;
    localparam logic [31:0] MB        = 32'hFFFF_0000;

    logic        clk = 0, rst_n = 0, req = 0, req0 = 0, we = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [7:0]  sw_in = 0;

    logic [31:0] rdata, ram_wdata, ram_rdata, rdata0, ram0_wdata, ram0_rdata;
    logic        ready, err, ram_en, ram_we, ready0, err0, ram0_en, ram0_we;
    logic [7:0]  ram_addr, ram0_addr, led_out, led0;

    mem_ctrl #(.MEM_WORDS(MEM_WORDS), .WAIT_CYCLES(2), .MMIO_BASE(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .sw_in(sw_in), .led_out(led_out));

    mem_ctrl #(.MEM_WORDS(MEM_WORDS), .WAIT_CYCLES(0), .MMIO_BASE(MB)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .ready(ready0), .err(err0), .ram_en(ram0_en), .ram_we(ram0_we),
        .ram_addr(ram0_addr), .ram_wdata(ram0_wdata), .ram_rdata(ram0_rdata),
        .sw_in(sw_in), .led_out(led0));

    always #5 clk = ~clk;

    // synchronous-read RAMs seen by the two controllers
    logic [31:0] mem [MEM_WORDS];
    logic [31:0] mem0[MEM_WORDS];
    always @(posedge clk) if (ram_en) begin
        if (ram_we) mem[ram_addr] <= ram_wdata; else ram_rdata <= mem[ram_addr];
    end
    always @(posedge clk) if (ram0_en) begin
        if (ram0_we) mem0[ram0_addr] <= ram0_wdata; else ram0_rdata <= mem0[ram0_addr];
    end

    // elapsed clock edges since reset release
    logic [31:0] tb_cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= 0; else tb_cyc <= tb_cyc + 1;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // reference model state
    logic [31:0] ref_mem [int];
    logic [31:0] ref_mem0[int];
    logic [7:0]  ref_led = 0;

    task automatic model(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [7:0] sw, input logic [31:0] c0, input int wc,
                         output logic [31:0] rd, output logic e, output int lat);
        rd = 0; e = 0; lat = 1;
        if (a % 4 != 0) e = 1;
        else if (longint'(a) < longint'(MEM_WORDS) * 4) begin
            lat = 3 + wc;
            if (sel) begin
                if (w) ref_mem0[int'(a / 4)] = d; else rd = ref_mem0[int'(a / 4)];
            end else begin
                if (w) ref_mem[int'(a / 4)] = d; else rd = ref_mem[int'(a / 4)];
            end
        end else if (a == MB) begin
            if (w) ref_led = d[7:0]; else rd = {24'b0, sw};
        end else if (a == MB + 4) begin
            if (!w) rd = c0;
        end else e = 1;
    endtask

    task automatic txn(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [7:0] sw, output logic [31:0] rd, output logic e, output int lat,
                       output int en_cnt, output logic [31:0] en_addr, output logic en_we,
                       output logic [31:0] c0);
        @(negedge clk);
        we = w; addr = a; wdata = d; sw_in = sw; c0 = tb_cyc;
        if (sel) req0 = 1; else req = 1;
        lat = 0; en_cnt = 0; en_addr = 0; en_we = 0; rd = 0; e = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (sel ? ram0_en : ram_en) begin
                en_cnt++;
                en_addr = 32'(sel ? ram0_addr : ram_addr);
                en_we   = sel ? ram0_we : ram_we;
            end
            if (sel ? ready0 : ready) begin
                lat = k; rd = sel ? rdata0 : rdata; e = sel ? err0 : err;
                break;
            end
        end
        req = 0; req0 = 0;
    endtask

    task automatic run_chk(input bit sel, input string nm, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input logic [7:0] sw, output logic [31:0] rd_o,
                           output logic [31:0] c0);
        logic [31:0] rd, erd, ea;
        logic        e, ee, ewe;
        int          lat, elat, en;
        txn(sel, w, a, d, sw, rd, e, lat, en, ea, ewe, c0);
        model(sel, w, a, d, sw, c0, sel ? 0 : 2, erd, ee, elat);
        rd_o = rd;
        if (lat == 0) begin
            chk({nm, " timeout"}, 0, 1);
            return;
        end
        chk({nm, " latency"}, lat, elat);
        chk({nm, " err"}, e, ee);
        if (!w || ee || elat > 1) chk({nm, " rdata"}, rd, erd);
        chk({nm, " ram_en count"}, en, (elat > 1) ? 1 : 0);
        if (elat > 1) begin
            chk({nm, " ram_addr"}, ea, a / 4);
            chk({nm, " ram_we"}, ewe, w);
        end
        if (!sel) chk({nm, " led_out"}, led_out, ref_led);
    endtask

    typedef struct {
        bit          w;
        logic [31:0] a, d;
        logic [7:0]  sw;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
        logic [7:0]  exp_led;
    } vec_t;

    initial begin
        vec_t        tbl[$];
        logic [31:0] rd, ea, c0, c1, r1, r2, dmy_rd;
        logic        e, ewe, dmy_e;
        int          lat, en, dmy_lat;
        int          rdy_at[$];
        bit          prev_rdy;
        int          adj;

        tbl.push_back('{1, 32'h10,       32'hDEADBEEF, 8'h00, 32'h0,        0, 5, 8'h00});
        tbl.push_back('{0, 32'h10,       32'h0,        8'h00, 32'hDEADBEEF, 0, 5, 8'h00});
        tbl.push_back('{1, MB,           32'h1A5,      8'h00, 32'h0,        0, 1, 8'hA5});
        tbl.push_back('{0, MB,           32'h0,        8'h3C, 32'h3C,       0, 1, 8'hA5});
        tbl.push_back('{0, 32'h2,        32'h0,        8'h00, 32'h0,        1, 1, 8'hA5});
        tbl.push_back('{0, 32'h0001_0000, 32'h0,       8'h00, 32'h0,        1, 1, 8'hA5});
        tbl.push_back('{1, MB + 4,       32'h55,       8'h00, 32'h0,        0, 1, 8'hA5});
        tbl.push_back('{1, MB + 1,       32'h77,       8'h00, 32'h0,        1, 1, 8'hA5});
        tbl.push_back('{1, 32'h3FC,      32'h12345678, 8'h00, 32'h0,        0, 5, 8'hA5});
        tbl.push_back('{0, 32'h3FC,      32'h0,        8'h00, 32'h12345678, 0, 5, 8'hA5});
        tbl.push_back('{0, 32'h400,      32'h0,        8'h00, 32'h0,        1, 1, 8'hA5});
        tbl.push_back('{0, MB + 8,       32'h0,        8'h00, 32'h0,        1, 1, 8'hA5});

        // reset values
        repeat (3) @(negedge clk);
        chk("reset ready", ready, 0);
        chk("reset err", err, 0);
        chk("reset rdata", rdata, 0);
        chk("reset led_out", led_out, 0);
        chk("reset ram_en", ram_en, 0);
        chk("reset ram_we", ram_we, 0);
        rst_n = 1;

        foreach (tbl[i]) begin
            txn(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].sw, rd, e, lat, en, ea, ewe, c0);
            model(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].sw, c0, 2, dmy_rd, dmy_e, dmy_lat);
            chk($sformatf("vec%0d latency", i), lat, tbl[i].exp_lat);
            chk($sformatf("vec%0d err", i), e, tbl[i].exp_err);
            if (!tbl[i].w || tbl[i].exp_err) chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d led_out", i), led_out, tbl[i].exp_led);
            chk($sformatf("vec%0d ram_en count", i), en, (tbl[i].exp_lat > 1) ? 1 : 0);
            if (tbl[i].exp_lat > 1) begin
                chk($sformatf("vec%0d ram_addr", i), ea, tbl[i].a >> 2);
                chk($sformatf("vec%0d ram_we", i), ewe, tbl[i].w);
            end
        end

        // zero wait states: ready three cycles after acceptance
        run_chk(1, "w0 write", 1, 32'h4, 32'hCAFE0004, 8'h0, rd, c0);
        run_chk(1, "w0 read", 0, 32'h4, 32'h0, 8'h0, rd, c0);

        // req held high across three reads
        @(negedge clk);
        we = 0; addr = 32'h10; req = 1; prev_rdy = 0; adj = 0;
        for (int k = 1; k <= 60 && rdy_at.size() < 3; k++) begin
            @(negedge clk);
            if (ready) begin
                if (prev_rdy) adj++;
                rdy_at.push_back(k);
                chk($sformatf("b2b rdata%0d", rdy_at.size()), rdata, 32'hDEADBEEF);
                if (rdy_at.size() == 3) req = 0;
            end
            prev_rdy = ready;
        end
        req = 0;
        chk("b2b ready count", rdy_at.size(), 3);
        chk("b2b adjacent ready", adj, 0);
        if (rdy_at.size() == 3) begin
            chk("b2b first latency", rdy_at[0], 5);
            chk("b2b gap1", rdy_at[1] - rdy_at[0], 6);
            chk("b2b gap2", rdy_at[2] - rdy_at[1], 6);
        end

        // reset during a store's ACCESS cycle
        run_chk(0, "pre write 0x20", 1, 32'h20, 32'h11112222, 8'h0, rd, c0);
        @(negedge clk);
        we = 1; addr = 32'h20; wdata = 32'h99999999; req = 1;
        @(negedge clk);
        chk("access ram_en", ram_en, 1);
        chk("access ram_we", ram_we, 1);
        rst_n = 0; req = 0;
        #1;
        chk("rst ram_we", ram_we, 0);
        chk("rst ram_en", ram_en, 0);
        chk("rst ready", ready, 0);
        chk("rst err", err, 0);
        chk("rst rdata", rdata, 0);
        chk("rst led_out", led_out, 0);
        @(negedge clk);
        rst_n = 1; ref_led = 0;
        run_chk(0, "post rst read 0x20", 0, 32'h20, 32'h0, 8'h0, rd, c0);
        run_chk(0, "cnt read a", 0, MB + 4, 32'h0, 8'h0, r1, c0);
        run_chk(0, "cnt read b", 0, MB + 4, 32'h0, 8'h0, r2, c1);
        chk("cnt delta", r2 - r1, c1 - c0);

        // randomized traffic
        for (int i = 0; i < 8; i++)
            run_chk(0, $sformatf("rnd init%0d", i), 1, 32'(i * 4), $urandom, 8'h0, rd, c0);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 5))
                0, 1: a = 32'($urandom_range(0, 7) * 4);
                2:    a = 32'($urandom_range(0, 300) * 4 + $urandom_range(1, 3));
                3:    a = MB;
                4:    a = MB + 4;
                default: a = ($urandom_range(0, 1) != 0) ? 32'(32'h400 + $urandom_range(0, 9999) * 4)
                                                         : 32'(MB + 8 + $urandom_range(0, 99) * 4);
            endcase
            run_chk(0, $sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, $urandom,
                    8'($urandom), rd, c0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
